// File: rtl/alu_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_pkg
// Shared definitions for the ALU operand/writeback stage: data and register
// widths, the NOP opcode, the instruction word layout and the in-flight slot
// record used to track instructions travelling through the ALU.
// ---------------------------------------------------------------------------
package alu_operand_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 4;
    localparam int STATUS_W = 5;
    localparam int OP_W     = 4;
    localparam int IMM_W    = 15;
    localparam int NREGS    = 16;

    localparam logic [OP_W-1:0] OP_NOP = 4'b0000;

    // Instruction word layout, most significant field first:
    // [31:28] op, [27:24] rd, [23:20] rs1, [19:16] rs2, [15] imm_sel, [14:0] imm
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              imm_sel;
        logic [IMM_W-1:0]  imm;
    } instr_t;

    // One in-flight instruction: does it write back, and to which register
    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
    } slot_t;

    // Immediates are two's complement and widened to the full datapath
    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
// 16 x 32 register file with two combinational read ports and one write
// port. Register 0 always reads zero and ignores writes. A read of the
// register being written on the same edge returns the write data, so the
// issuing instruction sees the value that lands on that edge.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset (clears all)
//   we, waddr, wdata    write port
//   raddr_a / rdata_a   read port A
//   raddr_b / rdata_b   read port B
// ---------------------------------------------------------------------------
module alu_regfile
    import alu_operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [NREGS];

    // Storage: reset clears every entry; writes to register 0 are dropped so
    // entry 0 stays zero even though reads of it are forced to zero anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports with same-edge write bypass
    always_comb begin
        rdata_a = mem[raddr_a];
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
    end

    always_comb begin
        rdata_b = mem[raddr_b];
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// Issue/writeback stage around an ALU with ALU_LAT cycles of latency.
// Instructions are accepted over a valid/ready handshake, their operands are
// read from the register file and registered onto in1/in2/op. ALU_LAT cycles
// later the ALU result is written back to rd and the status flags latched.
// Read-after-write hazards stall issue until the producer is on its
// writeback edge, where the register-file bypass supplies the value.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   instr_valid/ready     instruction handshake
//   instr                 32-bit instruction word
//   in1, in2, op          registered ALU operands and opcode (0 = bubble)
//   alu_result/status     ALU outputs, valid ALU_LAT cycles after issue
//   status_reg            status of the most recent writeback
//   wb_en, wb_addr        writeback taking place this cycle
// ---------------------------------------------------------------------------
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [31:0]         instr,
    output logic [DATA_W-1:0]   in1,
    output logic [DATA_W-1:0]   in2,
    output logic [OP_W-1:0]     op,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [STATUS_W-1:0] alu_status,
    output logic [STATUS_W-1:0] status_reg,
    output logic                wb_en,
    output logic [REG_AW-1:0]   wb_addr
);

    instr_t            dec;
    slot_t             pipe [ALU_LAT];
    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;

    assign dec     = instr_t'(instr);
    assign accept  = instr_valid && instr_ready;

    // The deepest slot is the one whose result is on alu_result this cycle
    assign wb_en   = pipe[ALU_LAT-1].vld;
    assign wb_addr = pipe[ALU_LAT-1].rd;

    alu_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (alu_result),
        .raddr_a (dec.rs1),
        .rdata_a (rs1_val),
        .raddr_b (dec.rs2),
        .rdata_b (rs2_val)
    );

    // A source register is unsafe while its producer sits in any slot short
    // of the completing one; the completing slot is covered by the bypass.
    // rs2 only matters when the instruction actually uses it.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < ALU_LAT-1; i++) begin
            if (pipe[i].vld && (pipe[i].rd != '0) &&
                ((pipe[i].rd == dec.rs1) ||
                 (!dec.imm_sel && (pipe[i].rd == dec.rs2)))) begin
                hazard = 1'b1;
            end
        end
    end

    assign instr_ready = !reset && !hazard;

    // In-flight tracking: bubbles and NOPs enter as invalid slots, so a stall
    // drains naturally as the pipe keeps shifting every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ALU_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{vld: accept && (dec.op != OP_NOP), rd: dec.rd};
            for (int i = 1; i < ALU_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Operand registers: a cycle without an accept issues a bubble and
    // leaves the operand values untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            op  <= OP_NOP;
            in1 <= '0;
            in2 <= '0;
        end else if (accept) begin
            op  <= dec.op;
            in1 <= rs1_val;
            in2 <= dec.imm_sel ? sext_imm(dec.imm) : rs2_val;
        end else begin
            op  <= OP_NOP;
        end
    end

    // Status is latched on every writeback, including ones aimed at r0
    always_ff @(posedge clk) begin
        if (reset) begin
            status_reg <= '0;
        end else if (wb_en) begin
            status_reg <= alu_status;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
// Bench for alu_operand_stage with ALU_LAT = 3. A behavioural ALU drives
// alu_result/alu_status with the configured latency. The reference model
// executes instructions architecturally in issue order and predicts ready
// from the edge at which each register's latest value becomes available.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;

    localparam int ALU_LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  op;
    logic [31:0] alu_result;
    logic [4:0]  alu_status;
    logic [4:0]  status_reg;
    logic        wb_en;
    logic [3:0]  wb_addr;

    int checks = 0;
    int errors = 0;

    alu_operand_stage #(.ALU_LAT(ALU_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .in1         (in1),
        .in2         (in2),
        .op          (op),
        .alu_result  (alu_result),
        .alu_status  (alu_status),
        .status_reg  (status_reg),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: op 1 add, 2 sub, 3 and, 4 or, 5 xor, 15 constant
    function automatic logic [31:0] alu_res(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        case (o)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd15:   return 32'h77;
            default: return (a ^ (b << 1)) + {28'd0, o};
        endcase
    endfunction

    function automatic logic [4:0] alu_st(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        r = alu_res(o, a, b);
        if (o == 4'd15) return 5'b10101;
        return {(r == 32'd0), r[31], o[2:0]};
    endfunction

    // ALU latency: results for operands registered at edge k appear in the
    // cycle before edge k+ALU_LAT
    logic [31:0] res_hist [ALU_LAT];
    logic [4:0]  st_hist  [ALU_LAT];

    always @(posedge clk) begin
        for (int i = ALU_LAT-1; i > 0; i--) begin
            res_hist[i] <= res_hist[i-1];
            st_hist[i]  <= st_hist[i-1];
        end
        res_hist[0] <= alu_res(op, in1, in2);
        st_hist[0]  <= alu_st(op, in1, in2);
    end

    assign alu_result = res_hist[ALU_LAT-2];
    assign alu_status = st_hist[ALU_LAT-2];

    // Reference model state
    typedef struct {
        int         edge_no;
        logic [3:0] rd;
        logic [4:0] st;
    } wb_t;

    wb_t         pend [$];
    logic [31:0] mrf [16];
    int          avail [16];
    int          edge_cnt = 0;
    logic [3:0]  exp_op;
    logic [31:0] exp_in1;
    logic [31:0] exp_in2;
    logic [4:0]  exp_status;

    function automatic logic [31:0] mk(input int o, input int rd, input int rs1, input int rs2,
                                       input int sel, input int imm);
        logic [31:0] w;
        w = {o[3:0], rd[3:0], rs1[3:0], rs2[3:0], sel[0], imm[14:0]};
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic modelReset();
        pend.delete();
        for (int i = 0; i < 16; i++) begin
            mrf[i]   = '0;
            avail[i] = 0;
        end
        exp_op     = '0;
        exp_in1    = '0;
        exp_in2    = '0;
        exp_status = '0;
    endtask

    // One clock cycle: check the state visible now, drive the inputs, check
    // ready, then advance the model across the next rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic rst,
                                 output logic acc, output logic dut_rdy);
        logic        exp_wb;
        logic        exp_rdy;
        logic        haz;
        logic [3:0]  o, rd, rs1, rs2;
        logic        sel;
        logic [31:0] a, b, r;
        @(negedge clk);
        checkOutput("op", {28'd0, op}, {28'd0, exp_op});
        checkOutput("in1", in1, exp_in1);
        checkOutput("in2", in2, exp_in2);
        checkOutput("status_reg", {27'd0, status_reg}, {27'd0, exp_status});
        exp_wb = (pend.size() > 0) && (pend[0].edge_no == edge_cnt + 1);
        checkOutput("wb_en", {31'd0, wb_en}, {31'd0, exp_wb});
        if (exp_wb) checkOutput("wb_addr", {28'd0, wb_addr}, {28'd0, pend[0].rd});

        reset       = rst;
        instr_valid = v;
        instr       = ins;
        {o, rd, rs1, rs2, sel} = ins[31:15];
        haz = ((rs1 != 0) && (edge_cnt + 1 < avail[rs1])) ||
              (!sel && (rs2 != 0) && (edge_cnt + 1 < avail[rs2]));
        exp_rdy = !rst && !haz;
        #1;
        dut_rdy = instr_ready;
        checkOutput("instr_ready", {31'd0, instr_ready}, {31'd0, exp_rdy});
        acc = v && exp_rdy;

        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            modelReset();
        end else begin
            if (pend.size() > 0 && pend[0].edge_no == edge_cnt) begin
                exp_status = pend[0].st;
                void'(pend.pop_front());
            end
            if (acc) begin
                a = mrf[rs1];
                b = sel ? {{17{ins[14]}}, ins[14:0]} : mrf[rs2];
                exp_op  = o;
                exp_in1 = a;
                exp_in2 = b;
                if (o != 0) begin
                    r = alu_res(o, a, b);
                    pend.push_back('{edge_no: edge_cnt + ALU_LAT, rd: rd, st: alu_st(o, a, b)});
                    if (rd != 0) begin
                        mrf[rd]   = r;
                        avail[rd] = edge_cnt + ALU_LAT;
                    end
                end
            end else begin
                exp_op = '0;
            end
        end
    endtask

    // Present one instruction until the model accepts it; counts cycles in
    // which the DUT held ready low
    task automatic issue(input logic [31:0] ins, output int stalls);
        logic acc, rdy;
        int   tries;
        stalls = 0;
        tries  = 0;
        acc    = 1'b0;
        while (!acc && tries < 10) begin
            applyStimulus(1'b1, ins, 1'b0, acc, rdy);
            if (!rdy) stalls++;
            tries++;
        end
        if (!acc) checkOutput("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc, rdy;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b0, acc, rdy);
    endtask

    initial begin
        logic acc, rdy;
        int   stalls;
        int   rs1, rs2;
        modelReset();
        repeat (2) @(posedge clk);
        applyStimulus(1'b0, 32'd0, 1'b1, acc, rdy);
        applyStimulus(1'b0, 32'd0, 1'b1, acc, rdy);

        // Immediate load into r1 and its writeback
        issue(mk(1, 1, 0, 0, 1, 5), stalls);
        idle(ALU_LAT + 1);

        // Dependent instruction right behind two immediate loads
        issue(mk(1, 1, 0, 0, 1, 5), stalls);
        issue(mk(1, 2, 0, 0, 1, 6), stalls);
        issue(mk(2, 3, 1, 2, 0, 0), stalls);
        checkOutput("dep_stall_cycles", stalls, ALU_LAT - 1);
        issue(mk(1, 4, 3, 0, 1, 32'h7FFF), stalls);
        checkOutput("dep_imm_stall_cycles", stalls, ALU_LAT - 1);
        idle(ALU_LAT + 1);

        // Writeback aimed at r0 still latches status
        issue(mk(15, 0, 1, 2, 0, 0), stalls);
        idle(ALU_LAT + 1);
        issue(mk(1, 5, 0, 0, 0, 0), stalls);
        idle(ALU_LAT);

        // Reset while an instruction is in flight, then read back every register
        issue(mk(1, 6, 0, 0, 1, 9), stalls);
        idle(1);
        applyStimulus(1'b0, 32'd0, 1'b1, acc, rdy);
        idle(ALU_LAT + 1);
        for (int i = 1; i < 16; i++) issue(mk(0, 0, i, i, 0, 0), stalls);

        // Eight independent instructions back to back
        for (int i = 1; i <= 8; i++) begin
            issue(mk(1, i, 0, 0, 1, i * 3), stalls);
            checkOutput("b2b_stall", stalls, 0);
        end
        idle(ALU_LAT + 2);

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            rs1 = $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            applyStimulus($urandom_range(0, 3) != 0,
                          mk($urandom_range(0, 15), $urandom_range(0, 7), rs1, rs2,
                             $urandom_range(0, 1), $urandom_range(0, 32767)),
                          $urandom_range(0, 79) == 0, acc, rdy);
        end
        idle(ALU_LAT + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue/writeback stage wrapped around the ALU.
- Accepts 32-bit instructions over a valid/ready handshake and decodes each one.
- Reads a 16x32 register file and drives registered in1/in2/op into the ALU.
- Writes alu_result back to the destination register and latches alu_status into a status register, ALU_LAT cycles after issue. RAW hazards are resolved by stall, plus same-edge bypass.

Parameters:
- ALU_LAT, 1: cycles from op/in1/in2 register update to alu_result/alu_status valid; range 1-4.
- NREGS, 16: register-file depth; fixed at 16 by the 4-bit register fields.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  instr holds a valid instruction
- instr_ready  out  1  stage accepts instr this cycle
- instr  in  32  [31:28] op, [27:24] rd, [23:20] rs1, [19:16] rs2, [15] imm_sel, [14:0] imm
- in1  out  32  ALU operand A (registered)
- in2  out  32  ALU operand B (registered)
- op  out  4  ALU opcode (registered); 4'b0000 is a bubble/NOP
- alu_result  in  32  ALU result
- alu_status  in  5  ALU status flags
- status_reg  out  5  last written ALU status
- wb_en  out  1  writeback happening this cycle (debug/verification)
- wb_addr  out  4  writeback register (debug/verification)

Behaviour:
- Reset, synchronous and active-high, applied at any point including mid-operation:
  - all rf entries, in1, in2, status_reg = 0; op = 4'b0000
  - in-flight pipe flushed; no writeback occurs for instructions issued before reset
  - instr_ready = 0 while reset is high.
- Accept: an instruction is accepted when instr_valid && instr_ready at a rising edge.
  - At that edge: op <= instr[31:28], in1 <= R(rs1), in2 <= imm_sel ? sign-extend(imm) : R(rs2).
  - No accept at an edge: op <= 4'b0000 (bubble); in1/in2 hold their values.
- R(x) for register reads:
  - R(0) = 0 always.
  - If a writeback to x happens on the same edge, R(x) = alu_result (bypass).
  - Otherwise R(x) = rf[x].
- In-flight tracking: an ALU_LAT-deep shift register of {vld, rd}.
  - Slot 0 loads {accepted && op!=0, rd}.
  - The slot at depth ALU_LAT is the completing slot.
- Writeback: when the completing slot has vld, on that edge:
  - rf[rd] <= alu_result unless rd == 0
  - status_reg <= alu_status (also when rd == 0)
  - wb_en = 1 and wb_addr = rd during that cycle.
- Hazard: asserted when any non-completing valid slot has rd != 0 and rd equal to rs1, or equal to rs2 with imm_sel = 0.
  - instr_ready = !reset && !hazard; this is combinational from the pipe and instr.
  - While stalled, bubbles keep advancing the pipe, so a stall lasts at most ALU_LAT-1 cycles.
- op = 0 instructions are accepted, never write back and never cause a hazard.
- Back-to-back independent instructions issue at 1 per cycle.
- instr_valid low produces bubbles; there is no other state change.

Decomposition:
- Shared package holds:
  - instruction field positions/widths
  - OP_NOP = 4'b0000
  - STATUS_W = 5, DATA_W = 32, REG_AW = 4.
- One sub-module, alu_regfile: 16x32, 2 combinational read ports with write-bypass, 1 write port, register 0 hardwired zero.

Test Plan:
1. Reset, then instr {op=1, rd=1, rs1=0, imm_sel=1, imm=5} -> next cycle in1=0, in2=5, op=1; with ALU add (op=1) returning 5, rf[1]=5 after ALU_LAT cycles; wb_en pulse with wb_addr=1.
2. Load r1=5 and r2=6 via immediates, then {op=2, rd=3, rs1=1, rs2=2} issued immediately after -> instr_ready low for ALU_LAT-1 cycles (0 stall when ALU_LAT=1, handled by bypass); in1=5, in2=6 at issue.
3. ALU_LAT=3, dependent pair -> exactly 2 stall cycles, bubbles (op=0) on the ALU inputs during the stall, correct operands on release.
4. Write to rd=0 with alu_result=0x77 and alu_status=5'b10101 -> rf[0] still reads 0; status_reg=5'b10101.
5. Assert reset for one cycle while an instruction is in flight -> no writeback afterwards; all rf entries, status_reg and op read 0; instr_ready returns 1 after reset drops.
6. 8 independent instructions with instr_valid held high -> 1 accepted per cycle, 8 wb_en pulses in issue order with correct wb_addr values.
